// File: rtl/sram_byte_ctrl_pkg.sv
// sram_byte_ctrl_pkg: shared constants and state encoding for the byte-serial SRAM initiator
package sram_byte_ctrl_pkg;
  localparam int BYTES = 4;
  localparam int MACRO_AW = 9;
  localparam int WORD_AW = MACRO_AW - 2;
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, SAMPLE, RESP} state_t;
endpackage

// File: rtl/sram_byte_ctrl.sv
// sram_byte_ctrl: splits 32-bit valid/ready word accesses into byte accesses on a single-port 8-bit macro
module sram_byte_ctrl
  import sram_byte_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [WORD_AW-1:0]  req_addr,
  input  logic [31:0]         req_wdata,
  input  logic [BYTES-1:0]    req_strb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [31:0]         rsp_rdata,
  output logic [MACRO_AW-1:0] sram_a,
  output logic                sram_ce,
  output logic                sram_csb,
  output logic                sram_web,
  output logic                sram_oeb,
  output logic [7:0]          sram_i,
  input  logic [7:0]          sram_o
);
  state_t r_state, w_next;
  logic r_we, w_we_n, w_accept, w_act, w_samp;
  logic [WORD_AW-1:0] r_addr, w_addr_n;
  logic [31:0] r_wdata, w_wdata_n;
  logic [BYTES-1:0] r_mask, w_mask_nxt, w_mask_clr;
  logic [1:0] w_lane, w_lane_nxt;
  assign req_ready = (r_state == IDLE) && !rst;
  assign rsp_valid = (r_state == RESP);
  assign w_accept = req_valid && req_ready;
  assign w_lane = r_mask[0] ? 2'd0 : r_mask[1] ? 2'd1 : r_mask[2] ? 2'd2 : 2'd3;
  assign w_lane_nxt = w_mask_nxt[0] ? 2'd0 : w_mask_nxt[1] ? 2'd1 : w_mask_nxt[2] ? 2'd2 : 2'd3;
  assign w_mask_clr = r_mask & ~(4'b0001 << w_lane);
  assign w_we_n = w_accept ? req_we : r_we;
  assign w_addr_n = w_accept ? req_addr : r_addr;
  assign w_wdata_n = w_accept ? req_wdata : r_wdata;
  assign w_act = (w_next == SETUP) || (w_next == STROBE);
  assign w_samp = (w_next == SAMPLE);
  always_comb begin
    w_next = r_state;
    w_mask_nxt = r_mask;
    case (r_state)
      IDLE: begin
        w_mask_nxt = w_accept ? (req_we ? req_strb : 4'hF) : r_mask;
        w_next = !w_accept ? IDLE : (|w_mask_nxt ? SETUP : RESP);
      end
      SETUP: w_next = STROBE;
      STROBE: begin
        w_mask_nxt = r_we ? w_mask_clr : r_mask;
        w_next = !r_we ? SAMPLE : (|w_mask_clr ? SETUP : RESP);
      end
      SAMPLE: begin
        w_mask_nxt = w_mask_clr;
        w_next = |w_mask_clr ? SETUP : RESP;
      end
      RESP: w_next = rsp_ready ? IDLE : RESP;
      default: w_next = IDLE;
    endcase
  end
  // Macro pins are registered from the next state so they change only on clk edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_mask <= '0;
      r_we <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
      rsp_rdata <= '0;
      sram_ce <= 1'b0;
      sram_csb <= 1'b1;
      sram_web <= 1'b1;
      sram_oeb <= 1'b1;
      sram_a <= '0;
      sram_i <= '0;
    end else begin
      r_state <= w_next;
      r_mask <= w_mask_nxt;
      r_we <= w_we_n;
      r_addr <= w_addr_n;
      r_wdata <= w_wdata_n;
      if (w_accept) rsp_rdata <= '0;
      else if (r_state == SAMPLE) rsp_rdata[{w_lane, 3'b000} +: 8] <= sram_o;
      sram_ce <= (w_next == STROBE);
      sram_csb <= !w_act;
      sram_web <= !(w_act && w_we_n);
      sram_oeb <= !w_samp;
      sram_a <= (w_act || w_samp) ? {w_addr_n, w_lane_nxt} : '0;
      sram_i <= w_act ? w_wdata_n[{w_lane_nxt, 3'b000} +: 8] : 8'h00;
    end
  end
endmodule

// File: tb/tb_sram_byte_ctrl.sv
// tb_sram_byte_ctrl: directed bench with a behavioural byte macro driven by sram_ce
module tb_sram_byte_ctrl;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready, req_we = 0;
  logic [6:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0] req_strb = '0;
  logic rsp_valid, rsp_ready = 0;
  logic [31:0] rsp_rdata;
  logic [8:0] sram_a;
  logic sram_ce, sram_csb, sram_web, sram_oeb;
  logic [7:0] sram_i, sram_o, dout;
  logic [7:0] mem [512];
  logic [8:0] ce_log [256];
  int ce_total = 0, csb_low = 0, checks = 0, fails = 0;

  sram_byte_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .sram_a(sram_a), .sram_ce(sram_ce),
    .sram_csb(sram_csb), .sram_web(sram_web), .sram_oeb(sram_oeb), .sram_i(sram_i), .sram_o(sram_o)
  );

  always #5 clk = ~clk;

  always @(posedge sram_ce) begin
    if (!sram_csb) begin
      if (!sram_web) mem[sram_a] <= sram_i;
      else dout <= mem[sram_a];
    end
    ce_log[ce_total[7:0]] <= sram_a;
    ce_total <= ce_total + 1;
  end
  assign sram_o = sram_oeb ? 8'h00 : dout;

  always @(posedge clk) if (!sram_csb) csb_low <= csb_low + 1;

  task automatic send(input logic we, input logic [6:0] a, input logic [31:0] d,
                      input logic [3:0] s, output int lat);
    int n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    req_valid = 1; req_we = we; req_addr = a; req_wdata = d; req_strb = s;
    @(posedge clk); #1;
    req_valid = 0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic ack();
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({req_ready, rsp_valid, rsp_rdata, sram_ce, sram_csb, sram_web, sram_oeb, sram_a, sram_i} !==
        {1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 9'h0, 8'h0}) begin
      fails++; $display("FAIL reset_values: got ready=%b valid=%b rdata=%h ce=%b csb=%b web=%b oeb=%b a=%h i=%h", req_ready, rsp_valid, rsp_rdata, sram_ce, sram_csb, sram_web, sram_oeb, sram_a, sram_i);
    end
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1) begin fails++; $display("FAIL ready_after_reset: got %b expected 1", req_ready); end
  endtask

  task automatic test_full();
    int lat, c0;
    c0 = ce_total;
    send(1, 7'd5, 32'hDEADBEEF, 4'hF, lat);
    checks++; if (lat != 9) begin fails++; $display("FAIL full_write_latency: got %0d expected 9", lat); end
    checks++; if (rsp_rdata !== 32'h0) begin fails++; $display("FAIL write_rdata_zero: got %h expected 00000000", rsp_rdata); end
    checks++; if (ce_total - c0 != 4) begin fails++; $display("FAIL full_write_ce: got %0d expected 4", ce_total - c0); end
    ack();
    c0 = ce_total;
    send(0, 7'd5, 32'h0, 4'h0, lat);
    checks++; if (lat != 13) begin fails++; $display("FAIL read_latency: got %0d expected 13", lat); end
    checks++; if (rsp_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL full_readback: got %h expected deadbeef", rsp_rdata); end
    checks++; if (ce_total - c0 != 4) begin fails++; $display("FAIL read_ce: got %0d expected 4", ce_total - c0); end
    ack();
  endtask

  task automatic test_partial();
    int lat, c0;
    c0 = ce_total;
    send(1, 7'd5, 32'h11223344, 4'b0101, lat);
    checks++; if (lat != 5) begin fails++; $display("FAIL partial_latency: got %0d expected 5", lat); end
    checks++; if (ce_total - c0 != 2) begin fails++; $display("FAIL partial_ce: got %0d expected 2", ce_total - c0); end
    checks++;
    if (ce_log[c0[7:0]] !== 9'd20 || ce_log[c0[7:0] + 8'd1] !== 9'd22) begin
      fails++; $display("FAIL partial_addrs: got %0d,%0d expected 20,22", ce_log[c0[7:0]], ce_log[c0[7:0] + 8'd1]);
    end
    ack();
    send(0, 7'd5, 32'h0, 4'h0, lat);
    checks++; if (rsp_rdata !== 32'hDE22BE44) begin fails++; $display("FAIL partial_readback: got %h expected de22be44", rsp_rdata); end
    ack();
  endtask

  task automatic test_zero_strb();
    int lat, c0, l0;
    c0 = ce_total; l0 = csb_low;
    send(1, 7'd9, 32'hFFFFFFFF, 4'h0, lat);
    checks++; if (lat != 1) begin fails++; $display("FAIL zero_strb_latency: got %0d expected 1", lat); end
    ack();
    checks++; if (ce_total != c0) begin fails++; $display("FAIL zero_strb_ce: got %0d expected 0", ce_total - c0); end
    checks++; if (csb_low != l0) begin fails++; $display("FAIL zero_strb_csb: got %0d low cycles expected 0", csb_low - l0); end
  endtask

  task automatic test_back_pressure();
    int lat;
    send(1, 7'd5, 32'hDEADBEEF, 4'hF, lat);
    ack();
    send(0, 7'd5, 32'h0, 4'h0, lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({rsp_valid, req_ready, rsp_rdata} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
        fails++; $display("FAIL backpressure_hold[%0d]: got valid=%b ready=%b rdata=%h expected 1 0 deadbeef", i, rsp_valid, req_ready, rsp_rdata);
      end
    end
    ack();
    checks++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      fails++; $display("FAIL backpressure_release: got valid=%b ready=%b expected 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid_write();
    int lat;
    send(1, 7'd10, 32'h0, 4'hF, lat);
    ack();
    req_valid = 1; req_we = 1; req_addr = 7'd10; req_wdata = 32'hAABBCCDD; req_strb = 4'hF;
    @(posedge clk); #1;
    req_valid = 0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if ({sram_csb, sram_a} !== {1'b0, 9'd42}) begin fails++; $display("FAIL mid_write_lane2_setup: got csb=%b a=%0d expected 0 42", sram_csb, sram_a); end
    rst = 1;
    #1;
    checks++;
    if ({req_ready, rsp_valid, sram_ce, sram_csb, sram_web, sram_oeb, sram_a, sram_i} !==
        {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 9'h0, 8'h0}) begin
      fails++; $display("FAIL async_reset: got ready=%b valid=%b ce=%b csb=%b web=%b oeb=%b a=%h i=%h", req_ready, rsp_valid, sram_ce, sram_csb, sram_web, sram_oeb, sram_a, sram_i);
    end
    #2 rst = 0;
    @(posedge clk); #1;
    send(0, 7'd10, 32'h0, 4'h0, lat);
    checks++; if (rsp_rdata !== 32'h0000CCDD) begin fails++; $display("FAIL mid_write_readback: got %h expected 0000ccdd", rsp_rdata); end
    ack();
  endtask

  task automatic test_wrap();
    int lat, c0;
    logic [8:0] ea;
    logic [7:0] ed;
    c0 = ce_total;
    send(1, 7'd127, 32'h01020304, 4'hF, lat);
    ack();
    for (int k = 0; k < 4; k++) begin
      ea = 9'd508 + 9'(k);
      ed = 8'd4 - 8'(k);
      checks++;
      if (ce_log[c0[7:0] + 8'(k)] !== ea || mem[ea] !== ed) begin
        fails++; $display("FAIL wrap_lane%0d: got addr=%0d data=%h expected %0d %h", k, ce_log[c0[7:0] + 8'(k)], mem[ea], ea, ed);
      end
    end
    send(0, 7'd127, 32'h0, 4'h0, lat);
    checks++; if (rsp_rdata !== 32'h01020304) begin fails++; $display("FAIL wrap_readback: got %h expected 01020304", rsp_rdata); end
    ack();
  endtask

  initial begin
    test_reset();
    test_full();
    test_partial();
    test_zero_strb();
    test_back_pressure();
    test_reset_mid_write();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
